// File: rtl/ser_param_serializer_pkg.sv
// Shared types and sizing helpers for the parametrised serializer.
// Optional prefetch slot is selected by defining SER_PREFETCH_EN.
package ser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

   // Width of the bit-count field carried with each word.
   function automatic int unsigned ser_mod_w(input int unsigned data_w);
      return $clog2(data_w);
   endfunction

   // One extra bit so a full-width burst length is representable.
   function automatic int unsigned ser_cnt_w(input int unsigned data_w);
      return $clog2(data_w) + 1;
   endfunction

   // Burst length: a count of zero stands for a full word.
   function automatic int unsigned ser_len(input int unsigned mod, input int unsigned data_w);
      return (mod == 0) ? data_w : mod;
   endfunction

endpackage

// File: rtl/ser_param_serializer_if.sv
// Word-side valid/ready handshake of the serializer.
// Used unchanged whether or not SER_PREFETCH_EN is defined.
interface ser_param_serializer_if #(
   parameter int unsigned DATA_W = 16
);
   import ser_pkg::*;

   localparam int unsigned MOD_W = ser_mod_w(DATA_W);

   logic [DATA_W-1:0] data_i;
   logic [MOD_W-1:0]  data_mod_i;
   logic              data_val_i;
   logic              ready_o;

   modport master (output data_i, output data_mod_i, output data_val_i, input ready_o);
   modport slave  (input data_i, input data_mod_i, input data_val_i, output ready_o);

endinterface

// File: rtl/ser_param_serializer_prefetch_buf.sv
// One-entry holding register for {word, length} between the producer and the shifter.
// Only compiled when SER_PREFETCH_EN is defined; the default build has no slot.
`ifdef SER_PREFETCH_EN
module ser_prefetch_buf #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 5
) (
   input  logic              clk_i,
   input  logic              arst_n_i,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CNT_W-1:0]  in_len,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_len
);

   logic              full_q;
   logic [DATA_W-1:0] data_q;
   logic [CNT_W-1:0]  len_q;

   assign in_ready  = !full_q;
   assign out_valid = full_q;
   assign out_data  = data_q;
   assign out_len   = len_q;

   // Fill on an accepted push, empty when the shifter takes the word.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         full_q <= 1'b0;
         data_q <= '0;
         len_q  <= '0;
      end else begin
         if (out_ready && full_q) begin
            full_q <= 1'b0;
         end
         if (in_valid && !full_q) begin
            full_q <= 1'b1;
            data_q <= in_data;
            len_q  <= in_len;
         end
      end
   end

endmodule
`endif

// File: rtl/ser_param_serializer.sv
// Parallel-to-serial converter: sends the selected bits of each accepted word,
// one per clock, MSB-first or LSB-first. Define SER_PREFETCH_EN for a one-word
// prefetch slot giving back-to-back bursts; otherwise one idle cycle separates bursts.
module ser_param_serializer
   import ser_pkg::*;
#(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MIN_LEN   = 3,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic                   clk_i,
   input  logic                   arst_n_i,
   ser_param_serializer_if.slave  in_if,
   output logic                   ser_data_o,
   output logic                   ser_data_val_o,
   output logic                   busy_o,
   output logic                   drop_o
);

   localparam int unsigned CNT_W = ser_cnt_w(DATA_W);

   ser_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              bit_d, val_d, busy_d, drop_d;

   int unsigned       in_len;
   logic              in_legal, accept, last, shifter_free, advance, load;
   logic [DATA_W-1:0] load_data;
   logic [CNT_W-1:0]  load_len;
   logic              slot_full_d;

   assign in_len       = ser_len(32'(in_if.data_mod_i), DATA_W);
   assign in_legal     = (in_len >= MIN_LEN);
   assign accept       = in_if.data_val_i && in_if.ready_o;
   assign last         = (state_q == SHIFT) && (cnt_q == len_q - CNT_W'(1));
   assign shifter_free = (state_q == IDLE) || last;
   assign advance      = (state_q == SHIFT) && !last;

`ifdef SER_PREFETCH_EN
   logic              slot_valid, slot_ready, slot_push, load_slot, load_in;
   logic [DATA_W-1:0] slot_data;
   logic [CNT_W-1:0]  slot_len;

   // A waiting word always wins over a new one; a new word bypasses the slot
   // whenever the shifter is free this cycle, otherwise it parks in the slot.
   assign load_slot   = shifter_free && slot_valid;
   assign load_in     = shifter_free && !slot_valid && accept && in_legal;
   assign slot_push   = accept && in_legal && !load_in;
   assign load        = load_in || load_slot;
   assign load_data   = load_slot ? slot_data : in_if.data_i;
   assign load_len    = load_slot ? slot_len : CNT_W'(in_len);
   assign slot_full_d = (slot_valid && !load_slot) || slot_push;
   assign in_if.ready_o = slot_ready;

   ser_prefetch_buf #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_slot (
      .clk_i     (clk_i),
      .arst_n_i  (arst_n_i),
      .in_valid  (slot_push),
      .in_ready  (slot_ready),
      .in_data   (in_if.data_i),
      .in_len    (CNT_W'(in_len)),
      .out_valid (slot_valid),
      .out_ready (load_slot),
      .out_data  (slot_data),
      .out_len   (slot_len)
   );
`else
   assign load          = accept && in_legal;
   assign load_data     = in_if.data_i;
   assign load_len      = CNT_W'(in_len);
   assign slot_full_d   = 1'b0;
   assign in_if.ready_o = !ser_data_val_o;
`endif

   // State register.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: start on a load, leave SHIFT after the last bit unless chaining.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load) state_d = SHIFT;
         SHIFT:   if (last && !load) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath next values: the first bit is presented straight from the
   // loaded word so it appears one cycle after the transfer.
   always_comb begin
      cnt_d   = '0;
      len_d   = len_q;
      shreg_d = shreg_q;
      bit_d   = 1'b0;
      val_d   = 1'b0;
      if (load) begin
         len_d = load_len;
         val_d = 1'b1;
         if (MSB_FIRST) begin
            bit_d   = load_data[DATA_W-1];
            shreg_d = load_data << 1;
         end else begin
            bit_d   = load_data[0];
            shreg_d = load_data >> 1;
         end
      end else if (advance) begin
         cnt_d = cnt_q + CNT_W'(1);
         val_d = 1'b1;
         if (MSB_FIRST) begin
            bit_d   = shreg_q[DATA_W-1];
            shreg_d = shreg_q << 1;
         end else begin
            bit_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
         end
      end
      drop_d = accept && !in_legal;
      busy_d = (state_d == SHIFT) || slot_full_d;
   end

   // Registered datapath and outputs.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         cnt_q          <= '0;
         len_q          <= '0;
         shreg_q        <= '0;
         ser_data_o     <= 1'b0;
         ser_data_val_o <= 1'b0;
         busy_o         <= 1'b0;
         drop_o         <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         len_q          <= len_d;
         shreg_q        <= shreg_d;
         ser_data_o     <= bit_d;
         ser_data_val_o <= val_d;
         busy_o         <= busy_d;
         drop_o         <= drop_d;
      end
   end

endmodule

// File: tb/tb_ser_param_serializer.sv
// Bench for ser_param_serializer (MSB-first instance checked every cycle against
// a bit-queue model, LSB-first instance checked with directed vectors).
// Expectations follow SER_PREFETCH_EN when it is defined.
module tb_ser_param_serializer;

   localparam int DW   = 16;
   localparam int MINL = 3;

   logic clk_i = 1'b0;
   logic arst_n_i;
   always #5 clk_i = ~clk_i;

   ser_param_serializer_if #(.DATA_W(16)) if_m ();
   ser_param_serializer_if #(.DATA_W(16)) if_l ();

   logic d_ser, d_val, d_busy, d_drop;
   logic l_ser, l_val, l_busy, l_drop;

   ser_param_serializer #(
      .DATA_W    (16),
      .MIN_LEN   (3),
      .MSB_FIRST (1'b1)
   ) u_dut (
      .clk_i          (clk_i),
      .arst_n_i       (arst_n_i),
      .in_if          (if_m),
      .ser_data_o     (d_ser),
      .ser_data_val_o (d_val),
      .busy_o         (d_busy),
      .drop_o         (d_drop)
   );

   ser_param_serializer #(
      .DATA_W    (16),
      .MIN_LEN   (3),
      .MSB_FIRST (1'b0)
   ) u_lsb (
      .clk_i          (clk_i),
      .arst_n_i       (arst_n_i),
      .in_if          (if_l),
      .ser_data_o     (l_ser),
      .ser_data_val_o (l_val),
      .busy_o         (l_busy),
      .drop_o         (l_drop)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: mdl_cur holds the bits of the running burst, front = bit on the line now.
   bit mdl_cur[$];
   bit mdl_slot[$];
   bit mdl_slot_full = 1'b0;
   bit mdl_drop = 1'b0;
   int mdl_drops = 0, dut_drops = 0, mdl_bits = 0, dut_bits = 0;

   function automatic bit mdl_ready();
`ifdef SER_PREFETCH_EN
      return !mdl_slot_full;
`else
      return (mdl_cur.size() == 0);
`endif
   endfunction

   always @(posedge clk_i or negedge arst_n_i) begin : model
      bit rdy, acc, legal;
      int len;
      bit inb[$];
      if (!arst_n_i) begin
         mdl_cur.delete();
         mdl_slot.delete();
         mdl_slot_full = 1'b0;
         mdl_drop = 1'b0;
      end else begin
         rdy   = mdl_ready();
         acc   = if_m.data_val_i && rdy;
         len   = (if_m.data_mod_i == 4'd0) ? DW : int'(if_m.data_mod_i);
         legal = (len >= MINL);
         inb.delete();
         for (int i = 0; i < len; i++) inb.push_back(if_m.data_i[DW-1-i]);
         if (mdl_cur.size() > 0) void'(mdl_cur.pop_front());
         if (mdl_cur.size() == 0 && mdl_slot_full) begin
            mdl_cur = mdl_slot;
            mdl_slot.delete();
            mdl_slot_full = 1'b0;
         end
         if (acc && legal) begin
            mdl_bits += len;
            if (mdl_cur.size() == 0) mdl_cur = inb;
            else begin
               mdl_slot = inb;
               mdl_slot_full = 1'b1;
            end
         end
         mdl_drop = acc && !legal;
         if (mdl_drop) mdl_drops++;
      end
   end

   always @(negedge clk_i) begin : compare
      bit ev, eb;
      ev = (mdl_cur.size() > 0);
      eb = ev ? mdl_cur[0] : 1'b0;
      check("ser_data_o", 32'(d_ser), 32'(eb));
      check("ser_data_val_o", 32'(d_val), 32'(ev));
      check("busy_o", 32'(d_busy), 32'(ev || mdl_slot_full));
      check("drop_o", 32'(d_drop), 32'(mdl_drop));
      check("ready_o", 32'(if_m.ready_o), 32'(mdl_ready()));
      if (d_drop) dut_drops++;
      if (d_val) dut_bits++;
   end

   // Called just after a falling edge; returns at the falling edge after the transfer.
   task automatic send(input logic [15:0] d, input logic [3:0] m, input bit scr);
      int unsigned k;
      k = 0;
      if_m.data_val_i = 1'b1;
      while (!mdl_ready() && k < 200) begin
         if (scr) begin
            if_m.data_i     = 16'($urandom);
            if_m.data_mod_i = 4'($urandom);
         end else begin
            if_m.data_i     = d;
            if_m.data_mod_i = m;
         end
         @(negedge clk_i);
         k++;
      end
      if (k >= 200) check("send_timeout", 32'(k), 32'(0));
      if_m.data_i     = d;
      if_m.data_mod_i = m;
      @(negedge clk_i);
      if_m.data_val_i = 1'b0;
      if_m.data_i     = 16'($urandom);
      if_m.data_mod_i = 4'($urandom);
   endtask

   task automatic wait_idle();
      int unsigned k;
      k = 0;
      while ((mdl_cur.size() > 0 || mdl_slot_full) && k < 100) begin
         @(negedge clk_i);
         k++;
      end
      if (k >= 100) check("idle_timeout", 32'(k), 32'(0));
      @(negedge clk_i);
   endtask

   initial begin : watchdog
      #3000000;
      n_errors++;
      $display("FAIL watchdog: actual=no finish required=finish");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [15:0] got16;
      logic [3:0]  got4;
      logic [2:0]  got3;
      int vc, p, r1, g, r2, viol;
      bit vlog[20];
      bit rlog[20];
      int unsigned r;

      arst_n_i = 1'b0;
      if_m.data_i = '0; if_m.data_mod_i = '0; if_m.data_val_i = 1'b0;
      if_l.data_i = '0; if_l.data_mod_i = '0; if_l.data_val_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("rst_ser", 32'(d_ser), 32'(0));
      check("rst_val", 32'(d_val), 32'(0));
      check("rst_busy", 32'(d_busy), 32'(0));
      check("rst_drop", 32'(d_drop), 32'(0));
      check("rst_ready", 32'(if_m.ready_o), 32'(1));
      arst_n_i = 1'b1;
      @(negedge clk_i);

      // Full-width word, MSB first.
      send(16'hA5F0, 4'd0, 1'b0);
      vc = 0;
      for (int i = 0; i < 16; i++) begin
         got16[15-i] = d_ser;
         vc += int'(d_val);
         @(negedge clk_i);
      end
      check("t1_word", 32'(got16), 32'h0000A5F0);
      check("t1_valid_cycles", 32'(vc), 32'd16);
      check("t1_val_after", 32'(d_val), 32'(0));
      wait_idle();

      // Shortest legal burst, then an illegal one.
      send(16'hC000, 4'd3, 1'b0);
      for (int i = 0; i < 3; i++) begin
         got3[2-i] = d_ser;
         @(negedge clk_i);
      end
      check("t2_bits", 32'(got3), 32'b110);
      check("t2_val_after", 32'(d_val), 32'(0));
      wait_idle();
      send(16'hC000, 4'd2, 1'b0);
      check("t2_drop_pulse", 32'(d_drop), 32'(1));
      check("t2_drop_noval", 32'(d_val), 32'(0));
      @(negedge clk_i);
      check("t2_drop_end", 32'(d_drop), 32'(0));
      check("t2_drop_noval2", 32'(d_val), 32'(0));
      wait_idle();

      // LSB-first instance.
      check("t3_ready", 32'(if_l.ready_o), 32'(1));
      if_l.data_i = 16'h0005; if_l.data_mod_i = 4'd4; if_l.data_val_i = 1'b1;
      @(negedge clk_i);
      if_l.data_val_i = 1'b0;
      vc = 0;
      for (int i = 0; i < 4; i++) begin
         got4[i] = l_ser;
         vc += int'(l_val);
         @(negedge clk_i);
      end
      check("t3_bits", 32'(got4), 32'b0101);
      check("t3_valid_cycles", 32'(vc), 32'd4);
      check("t3_val_after", 32'(l_val), 32'(0));

      // Two words with valid held high.
      fork
         begin
            send(16'hF000, 4'd4, 1'b0);
            send(16'h5555, 4'd5, 1'b0);
         end
         begin
            for (int i = 0; i < 20; i++) begin
               @(negedge clk_i);
               vlog[i] = d_val;
               rlog[i] = if_m.ready_o;
            end
         end
      join
      p = 0; r1 = 0; g = 0; r2 = 0; viol = 0;
      for (int i = 0; i < 20; i++) if (vlog[i] && rlog[i]) viol++;
      while (p < 20 && !vlog[p]) p++;
      while (p < 20 && vlog[p]) begin r1++; p++; end
      while (p < 20 && !vlog[p]) begin g++; p++; end
      while (p < 20 && vlog[p]) begin r2++; p++; end
`ifdef SER_PREFETCH_EN
      check("t4_run", 32'(r1), 32'd9);
      check("t4_no_second_run", 32'(r2), 32'd0);
`else
      check("t4_run1", 32'(r1), 32'd4);
      check("t4_gap", 32'(g), 32'd1);
      check("t4_run2", 32'(r2), 32'd5);
      check("t4_ready_low_in_burst", 32'(viol), 32'd0);
`endif
      wait_idle();

      // Asynchronous reset in the middle of a burst.
      send(16'hBEEF, 4'd0, 1'b0);
      repeat (6) @(negedge clk_i);
      #2 arst_n_i = 1'b0;
      #1;
      check("t5_ser", 32'(d_ser), 32'(0));
      check("t5_val", 32'(d_val), 32'(0));
      check("t5_busy", 32'(d_busy), 32'(0));
      check("t5_drop", 32'(d_drop), 32'(0));
      @(negedge clk_i);
      @(negedge clk_i);
      arst_n_i = 1'b1;
      #1;
      check("t5_ready_after", 32'(if_m.ready_o), 32'(1));
      send(16'hA000, 4'd3, 1'b0);
      check("t5_first_bit", 32'(d_ser), 32'(1));
      check("t5_first_val", 32'(d_val), 32'(1));
      @(negedge clk_i);
      check("t5_second_bit", 32'(d_ser), 32'(0));
      @(negedge clk_i);
      check("t5_third_bit", 32'(d_ser), 32'(1));
      @(negedge clk_i);
      check("t5_val_after", 32'(d_val), 32'(0));
      wait_idle();

      // Random words; data/mod scrambled while the block is not ready.
      mdl_bits = 0; dut_bits = 0; mdl_drops = 0; dut_drops = 0;
      for (int w = 0; w < 3000; w++) begin
         r = $urandom_range(0, 3);
         if (r == 0) begin
            if_m.data_val_i = 1'b0;
            if_m.data_i     = 16'($urandom);
            @(negedge clk_i);
         end else begin
            send(16'($urandom), 4'($urandom), 1'b1);
         end
      end
      wait_idle();
      check("t6_drop_count", 32'(dut_drops), 32'(mdl_drops));
      check("t6_bit_count", 32'(dut_bits), 32'(mdl_bits));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
